prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and instruction memory for the Forth core. Accepts a framed byte stream from a serial receiver, assembles 16-bit instruction words into on-chip instruction RAM, and holds the core in reset until a complete, valid image is loaded. In run mode it serves the core's instruction fetch port with a one-cycle synchronous read, which matches the core's post-reset wait cycle.

## Interface

Parameters:
- `iaddr_width`, default 10: instruction address width; RAM depth is 2**iaddr_width words.
- `instr_width`, default 16: instruction word width; fixed at 16 for the byte protocol.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-low reset.
- `iaddr`  in  iaddr_width: core fetch address, driven by the core's next-IP.
- `idata`  out  instr_width: registered RAM read data, `mem[iaddr]` from the previous cycle.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte. A transfer occurs on a cycle with `rx_valid & rx_ready`.
- `cpu_reset`  out  1: synchronous active-high reset to the core.
- `load_done`  out  1: a valid image is loaded and the core is running.
- `load_error`  out  1: sticky flag. The last frame was rejected.

## Operation

- Frame format: header `8'hA5`, then LEN_H and LEN_L (word count N, big-endian), then 2N data bytes (each word big-endian), then CSUM (XOR of all 2N data bytes). CSUM is present only if the feature in Configuration is compiled in.
- FSM states: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, ERR, RUN. Transitions occur only on accepted bytes, except ERR.
- IDLE: `8'hA5` moves to LEN_H and clears `load_error`. Any other byte is discarded.
- LEN_H → LEN_L. LEN_L latches N.
  - If N == 0 or N > 2**iaddr_width, go to ERR.
  - Otherwise go to DATA_H and clear the word address counter to 0.
- DATA_H latches the high byte and moves to DATA_L.
- DATA_L writes `{hi, byte}` to `mem[addr]` and increments `addr`.
  - While `addr+1 < N`, go back to DATA_H.
  - After the last word, go to CSUM, or to RUN if the feature is compiled out.
- The running XOR covers every data byte and is cleared on leaving IDLE.
- CSUM: a match goes to RUN. A mismatch goes to ERR.
- ERR: lasts exactly one cycle with `rx_ready` = 0. Sets `load_error` and then goes to IDLE.
- RUN: `load_done` = 1. An accepted `8'hA5` restarts loading: go to LEN_H, drop `load_done`, assert `cpu_reset`. Other bytes are discarded.
- `cpu_reset` = 1 in every state except RUN.
- `rx_ready` = 1 in every state except ERR and except while `reset` is asserted.
- RAM contents written by a previous or partial load are retained. A failed load leaves partially overwritten RAM, and the core stays in reset.
- RAM read and write in the same cycle to the same address: `idata` returns the old data (read-before-write).
- Address counter width is iaddr_width+1 so that the N = 2**iaddr_width case terminates without wrap.

## Timing

- Reset values:
  - `idata` = 0, `rx_ready` = 0, `cpu_reset` = 1, `load_done` = 0, `load_error` = 0.
  - State IDLE, address counter 0, checksum 0.
  - RAM contents are undefined.
- Reset asserted mid-frame aborts the frame immediately. After release, the loader is in IDLE.
- Read latency is 1 cycle: `idata` at edge k+1 = `mem[iaddr at edge k]`.
- The byte that completes a frame enters RUN on its accept edge. `cpu_reset` falls and `load_done` rises on that same edge; both are registered outputs.
- The write to `mem` for a DATA_L byte takes effect on the accept edge. The first core fetch is at least 1 cycle later.
- A header accepted in RUN raises `cpu_reset` on the accept edge.
- `load_error` rises on the edge leaving ERR. It falls on the edge that accepts the next header.

## Configuration

- `PROG_LOADER_CSUM_EN` defined: the CSUM state and the XOR accumulator exist, and the frame ends with a checksum byte.
- Undefined: no CSUM state and no accumulator. DATA_L of the last word goes directly to RUN, and only the length check can raise `load_error`.

## Structure

- Shared package `forth_pkg` holds:
  - the header constant `8'hA5`;
  - the loader state enum;
  - the instruction width constant, shared with the core.
- Sub-module `prog_ram`: single write port and single synchronous read port, read-before-write, parameterised by iaddr_width and instr_width. The FSM, counters and checksum stay in `prog_loader`.

## Test plan

- Reset, no stream → `cpu_reset` = 1, `load_done` = 0, `rx_ready` = 1 after release.
- Frame A5 00 02 80 01 00 02 83 → `mem[0]` = 0x8001, `mem[1]` = 0x0002, `load_done` = 1, `cpu_reset` = 0. Then `iaddr` = 1 gives `idata` = 0x0002 one cycle later.
- Same frame with CSUM 0x84 → one cycle with `rx_ready` = 0, `load_error` = 1, `cpu_reset` stays 1. The next good frame clears `load_error` at its header.
- LEN = 0x0000 and LEN = 0x0401 (iaddr_width = 10) → ERR and `load_error`; no RAM write occurs.
- Full 1024-word image with random `rx_valid` gaps → all words read back correctly, and the address counter does not wrap.
- In RUN, send A5 00 01 E0 40 (plus CSUM 0xA0 if enabled) → `cpu_reset` reasserts on the header, `mem[0]` = 0xE040, and RUN is re-entered. Asserting `reset` mid-frame → IDLE with all outputs at their reset values.

Source files
------------

// File: rtl/forth_pkg.sv
// Definitions shared by the Forth core and its program loader: frame
// header byte, loader state encoding and the instruction word width.
package forth_pkg;

  localparam int instr_width_c = 16;
  localparam logic [7:0] frame_header = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_CSUM,
    ST_ERR,
    ST_RUN
  } loader_state_t;

  // A frame length is usable when it is non-zero and fits the RAM depth.
  function automatic logic len_ok(input logic [15:0] n, input int aw);
    return (n != 16'd0) && (32'(n) <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Instruction RAM: one write port and one registered read port. A read and
// a write to the same address in one cycle returns the previous contents.
module prog_ram #(
  parameter int iaddr_width = 10,
  parameter int instr_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [iaddr_width-1:0] waddr,
  input  logic [instr_width-1:0] wdata,
  input  logic [iaddr_width-1:0] raddr,
  output logic [instr_width-1:0] rdata
);

  localparam int depth = 1 << iaddr_width;

  logic [instr_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; the array keeps whatever was loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader for the Forth core: receives a framed byte stream, fills the
// instruction RAM and holds the core in reset until a valid image is loaded.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module prog_loader
  import forth_pkg::*;
#(
  parameter int iaddr_width = 10,
  parameter int instr_width = instr_width_c
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [instr_width-1:0] idata,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic                   load_error,
  output logic [2:0]             dbg_state
);

  // Byte handshake: a byte moves only on a rising edge where rx_valid and
  // rx_ready are both high; rx_ready is registered and never depends on rx_valid.

  localparam logic [iaddr_width:0] addr_one = 1;

  loader_state_t state, next_state;

  logic [7:0]           len_hi_q;
  logic [15:0]          len_q;
  logic [15:0]          len_next;
  logic [iaddr_width:0] addr_q;
  logic [7:0]           hi_q;
  logic                 acc;
  logic                 header_acc;
  logic                 more_words;
  logic                 ram_we;

  assign acc        = rx_valid & rx_ready;
  assign header_acc = acc && (rx_data == frame_header) &&
                      ((state == ST_IDLE) || (state == ST_RUN));
  assign len_next   = {len_hi_q, rx_data};
  // Counter is one bit wider than the RAM address, so a full-depth image ends cleanly.
  assign more_words = (32'(addr_q) + 32'd1) < 32'(len_q);
  assign dbg_state  = state;

`ifdef PROG_LOADER_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (header_acc) begin
      csum_q <= '0;
    end else if (acc && ((state == ST_DATA_H) || (state == ST_DATA_L))) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (header_acc) next_state = ST_LEN_H;
      end
      ST_LEN_H: begin
        if (acc) next_state = ST_LEN_L;
      end
      ST_LEN_L: begin
        if (acc) next_state = len_ok(len_next, iaddr_width) ? ST_DATA_H : ST_ERR;
      end
      ST_DATA_H: begin
        if (acc) next_state = ST_DATA_L;
      end
      ST_DATA_L: begin
        if (acc) begin
          ram_we = 1'b1;
          if (more_words) begin
            next_state = ST_DATA_H;
          end else begin
`ifdef PROG_LOADER_CSUM_EN
            next_state = ST_CSUM;
`else
            next_state = ST_RUN;
`endif
          end
        end
      end
      ST_CSUM: begin
`ifdef PROG_LOADER_CSUM_EN
        if (acc) next_state = (rx_data == csum_q) ? ST_RUN : ST_ERR;
`else
        next_state = ST_IDLE;
`endif
      end
      ST_ERR: begin
        next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (header_acc) next_state = ST_LEN_H;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      rx_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state     <= next_state;
      // Outputs follow the state being entered, so they change on the accept edge.
      rx_ready  <= (next_state != ST_ERR);
      cpu_reset <= (next_state != ST_RUN);
      load_done <= (next_state == ST_RUN);

      if (state == ST_ERR) begin
        load_error <= 1'b1;
      end else if (header_acc) begin
        load_error <= 1'b0;
      end

      if (acc && (state == ST_LEN_H)) len_hi_q <= rx_data;
      if (acc && (state == ST_LEN_L)) begin
        len_q  <= len_next;
        addr_q <= '0;
      end
      if (acc && (state == ST_DATA_H)) hi_q <= rx_data;
      if (ram_we) addr_q <= addr_q + addr_one;
    end
  end

  prog_ram #(
    .iaddr_width(iaddr_width),
    .instr_width(instr_width)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(addr_q[iaddr_width-1:0]),
    .wdata({hi_q, rx_data}),
    .raddr(iaddr),
    .rdata(idata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames with hand-computed
// results, status and RAM read-back checked by a negedge monitor.
module tb_prog_loader;

  localparam int aw = 10;
  localparam int depth = 1 << aw;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [aw-1:0] iaddr = '0;
  logic [15:0]   idata;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  prog_loader #(.iaddr_width(aw), .instr_width(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .iaddr     (iaddr),
    .idata     (idata),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_error(load_error),
    .dbg_state (dbg_state)
  );

  // Scoreboard queues: read data and status {rx_ready,cpu_reset,load_done,load_error}
  logic [15:0] exp_q[$];
  string       exp_name_q[$];
  logic [3:0]  st_q[$];
  string       st_name_q[$];
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;
  logic        st_req = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [15:0] mon_exp16;
  logic [3:0]  mon_exp4;
  logic [3:0]  mon_act4;
  string       mon_name;

  logic [15:0] img [depth];
  logic [7:0]  fr[$];
  logic [7:0]  img_csum;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (st_req) begin
      vectors++;
      if (st_q.size() == 0) begin
        miscompares++;
        $display("FAIL status_queue: status check with empty expected queue");
      end else begin
        mon_exp4 = st_q.pop_front();
        mon_name = st_name_q.pop_front();
        mon_act4 = {rx_ready, cpu_reset, load_done, load_error};
        if (mon_act4 !== mon_exp4) begin
          miscompares++;
          $display("FAIL %s: {rx_ready,cpu_reset,load_done,load_error} got %b expected %b",
                   mon_name, mon_act4, mon_exp4);
        end
      end
    end
    if (rd_pend) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_queue: read data with empty expected queue");
      end else begin
        mon_exp16 = exp_q.pop_front();
        mon_name  = exp_name_q.pop_front();
        if (idata !== mon_exp16) begin
          miscompares++;
          $display("FAIL %s: idata got %h expected %h", mon_name, idata, mon_exp16);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (rx_ready) break;
      if (i == 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: rx_ready got 0 expected 1 within 50 cycles (byte %h)", b);
        rx_valid = 1'b0;
        return;
      end
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input logic [7:0] csum, input int gap);
    foreach (b[i]) send_byte(b[i], gap);
`ifdef PROG_LOADER_CSUM_EN
    send_byte(csum, gap);
`else
    if (csum === 8'hxx) tick();
`endif
  endtask

  task automatic check_st(input logic [3:0] e, input string nm);
    st_q.push_back(e);
    st_name_q.push_back(nm);
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
  endtask

  task automatic read_word(input int a, input logic [15:0] e, input string nm);
    iaddr = aw'(a);
    exp_q.push_back(e);
    exp_name_q.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    img_csum = '0;
    for (int i = 0; i < depth; i++) begin
      img[i] = 16'((i * 40503) + 12345) ^ 16'hA5C3;
      img_csum = img_csum ^ img[i][15:8] ^ img[i][7:0];
    end

    repeat (3) @(posedge clk);
    #1;
    check_st(4'b0100, "reset_status");
    read_word(0, 16'h0000, "reset_idata");
    reset = 1'b1;
    tick();
    check_st(4'b1100, "after_release");

    // Two-word frame
    fr = '{8'hA5, 8'h00, 8'h02, 8'h80, 8'h01, 8'h00, 8'h02};
    send_frame(fr, 8'h83, 0);
    check_st(4'b1010, "frame1_run");
    read_word(0, 16'h8001, "frame1_mem0");
    read_word(1, 16'h0002, "frame1_mem1");

`ifdef PROG_LOADER_CSUM_EN
    fr = '{8'hA5, 8'h00, 8'h02, 8'h80, 8'h01, 8'h00, 8'h02};
    send_frame(fr, 8'h84, 0);
    check_st(4'b0100, "csum_err_cycle");
    check_st(4'b1101, "csum_err_flag");
    send_byte(8'hA5, 0);
    check_st(4'b1100, "csum_err_clear_hdr");
    fr = '{8'h00, 8'h02, 8'h80, 8'h01, 8'h00, 8'h02};
    send_frame(fr, 8'h83, 0);
    check_st(4'b1010, "csum_recover_run");
`endif

    // Length zero, from RUN
    send_byte(8'hA5, 0);
    check_st(4'b1100, "run_hdr_len0");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_st(4'b0100, "len0_err_cycle");
    check_st(4'b1101, "len0_err_flag");
    send_byte(8'h12, 0);
    check_st(4'b1101, "idle_discard");
    // Length one past the RAM depth
    fr = '{8'hA5, 8'h04, 8'h01};
    foreach (fr[i]) send_byte(fr[i], 0);
    check_st(4'b0100, "len1025_err_cycle");
    check_st(4'b1101, "len1025_err_flag");
    read_word(0, 16'h8001, "len_err_mem0");
    read_word(1, 16'h0002, "len_err_mem1");

    // Full-depth image with random valid gaps
    send_byte(8'hA5, 2);
    check_st(4'b1100, "hdr_clears_err");
    send_byte(8'h04, 2);
    send_byte(8'h00, 2);
    for (int i = 0; i < depth; i++) begin
      send_byte(img[i][15:8], 2);
      send_byte(img[i][7:0], 2);
    end
`ifdef PROG_LOADER_CSUM_EN
    send_byte(img_csum, 2);
`endif
    check_st(4'b1010, "full_run");
    for (int i = 0; i < depth; i++) read_word(i, img[i], "full_rd");

    // Reload from RUN
    send_byte(8'hA5, 0);
    check_st(4'b1100, "restart_hdr");
    fr = '{8'h00, 8'h01, 8'hE0, 8'h40};
    send_frame(fr, 8'hA0, 0);
    check_st(4'b1010, "restart_run");
    read_word(0, 16'hE040, "restart_mem0");
    read_word(1, img[1], "restart_mem1");

    // Reset in the middle of a frame
    fr = '{8'hA5, 8'h00, 8'h02, 8'h80};
    foreach (fr[i]) send_byte(fr[i], 0);
    reset = 1'b0;
    check_st(4'b0100, "midreset_status");
    read_word(0, 16'h0000, "midreset_idata");
    reset = 1'b1;
    tick();
    check_st(4'b1100, "midreset_release");
    fr = '{8'h00, 8'h01, 8'h12, 8'h34};
    foreach (fr[i]) send_byte(fr[i], 0);
    check_st(4'b1100, "post_reset_idle");
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    send_frame(fr, 8'h26, 0);
    check_st(4'b1010, "post_reset_run");
    read_word(0, 16'h1234, "post_reset_mem0");
    read_word(1, img[1], "ram_retained");

    repeat (3) tick();
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: pending reads %0d status %0d expected 0", exp_q.size(), st_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
